// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - shared control-bit indices, field positions and immediate helper for the decode stage
package id_stage_pipe_pkg;

    // Bit positions inside the decoded control word
    localparam int CB_REGWRITE = 0;
    localparam int CB_MEMREAD  = 1;
    localparam int CB_USESRT   = 2;
    localparam int CB_JUMP     = 3;
    localparam int CB_JUMPREG  = 4;
    localparam int CB_ZEROEXT  = 5;

    // Register index fields inside the instruction word
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;

    // Widest datapath the immediate helper serves; callers truncate to XLEN
    localparam int IMM_MAX_W = 64;

    // Sign- or zero-extend the 16-bit immediate field
    function automatic logic [IMM_MAX_W-1:0] imm_ext(input logic [15:0] imm, input logic zeroExt);
        logic fill;
        fill    = ~zeroExt & imm[15];
        imm_ext = {{(IMM_MAX_W-16){fill}}, imm};
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - IF/ID-side and EX-side handshakes of the decode stage
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int RW     = 5,
    parameter int CTRL_W = 18
);
    // Upstream (IF/ID register) side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc4;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RW-1:0]     in_rd;

    // Downstream (EX) side, driven from the ID/EX register
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_rs_data;
    logic [XLEN-1:0]   out_rt_data;
    logic [XLEN-1:0]   out_imm;
    logic [RW-1:0]     out_rs;
    logic [RW-1:0]     out_rt;
    logic [RW-1:0]     out_rd;

    // Surrounding pipeline: feeds instructions and accepts decoded ops
    modport master (
        output in_valid, in_instr, in_pc4, in_ctrl, in_rd,
        input  in_ready,
        input  out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd,
        output out_ready
    );

    // Decode stage itself
    modport slave (
        input  in_valid, in_instr, in_pc4, in_ctrl, in_rd,
        output in_ready,
        output out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd,
        input  out_ready
    );

endinterface

// File: rtl/id_stage_pipe_regfile.sv
// rtl/id_stage_pipe_regfile.sv - two-read one-write register file with write-first bypass, reg 0 reads zero
module id_stage_pipe_regfile #(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic [RW-1:0]   rdAddrA,
    output logic [XLEN-1:0] rdDataA,
    input  logic [RW-1:0]   rdAddrB,
    output logic [XLEN-1:0] rdDataB,
    input  logic            wrEn,
    input  logic [RW-1:0]   wrAddr,
    input  logic [XLEN-1:0] wrData
);
    logic [XLEN-1:0] mem [NREG];
    logic            wrLive;

    // Writes to register 0 are dropped so it never needs storage semantics
    assign wrLive = wrEn && (wrAddr != '0);

    // Storage is deliberately not reset; software initialises registers it reads
    always_ff @(posedge clk) begin
        if (wrLive) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Same-cycle write is visible to readers (write-first)
    always_comb begin
        rdDataA = mem[rdAddrA];
        if (rdAddrA == '0) begin
            rdDataA = '0;
        end else if (wrLive && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end
    end

    // Second read port, same rules as the first
    always_comb begin
        rdDataB = mem[rdAddrB];
        if (rdAddrB == '0) begin
            rdDataB = '0;
        end else if (wrLive && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage with MEM forwarding, load-use/jr stalls, jump resolution and ID/EX register
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int  XLEN     = 32,
    parameter int  NREG     = 32,
    parameter int  CTRL_W   = 18,
    parameter int  LOAD_LAT = 1,
    parameter int  PERF_W   = 16,
    localparam int RW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    id_stage_pipe_if.slave    pipe,
    input  logic              wb_en,
    input  logic [RW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              fwd_en,
    input  logic [RW-1:0]     fwd_addr,
    input  logic [XLEN-1:0]   fwd_data,
    input  logic              flush,
    output logic              jump_taken,
    output logic [XLEN-1:0]   jump_target,
    output logic [PERF_W-1:0] perf_stall
);
    // LOAD_LAT is at most 7, so three bits hold the remaining bubble count
    localparam int SCNT_W = 3;

    logic [RW-1:0]     rs;
    logic [RW-1:0]     rt;
    logic [XLEN-1:0]   rfRs;
    logic [XLEN-1:0]   rfRt;
    logic [XLEN-1:0]   rsData;
    logic [XLEN-1:0]   rtData;
    logic [SCNT_W-1:0] sCnt;
    logic              advance;
    logic              hazLu;
    logic              hazJr;
    logic              stall;
    logic              inReady;
    logic              accept;
    logic              isJump;
    logic              isJumpReg;
    logic              unusedBits;

    // Opcode bits and the low PC bits play no part in decode here
    assign unusedBits = ^{pipe.in_instr[31:26], pipe.in_pc4[27:0]};

    assign rs = pipe.in_instr[RS_LSB +: RW];
    assign rt = pipe.in_instr[RT_LSB +: RW];

    id_stage_pipe_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rdAddrA (rs),
        .rdDataA (rfRs),
        .rdAddrB (rt),
        .rdDataB (rfRt),
        .wrEn    (wb_en),
        .wrAddr  (wb_addr),
        .wrData  (wb_data)
    );

    // Operand priority: hard zero, then the MEM-stage result, then the register file
    function automatic logic [XLEN-1:0] pickOperand(
        input logic [RW-1:0]   idx,
        input logic [XLEN-1:0] rfData,
        input logic            fEn,
        input logic [RW-1:0]   fAddr,
        input logic [XLEN-1:0] fData
    );
        if (idx == '0) begin
            return '0;
        end
        if (fEn && (fAddr == idx)) begin
            return fData;
        end
        return rfData;
    endfunction

    // Forwarding muxes for both source operands
    always_comb begin
        rsData = pickOperand(rs, rfRs, fwd_en, fwd_addr, fwd_data);
        rtData = pickOperand(rt, rfRt, fwd_en, fwd_addr, fwd_data);
    end

    assign advance = ~pipe.out_valid | pipe.out_ready;

    // A load in ID/EX has no data yet for the instruction in ID
    assign hazLu = pipe.out_valid & pipe.out_ctrl[CB_MEMREAD] & (pipe.out_rd != '0)
                 & ((pipe.out_rd == rs) | (pipe.in_ctrl[CB_USESRT] & (pipe.out_rd == rt)));

    // jr needs its target now, but an EX result only reaches ID via MEM forwarding
    assign hazJr = pipe.in_ctrl[CB_JUMPREG] & pipe.out_valid & pipe.out_ctrl[CB_REGWRITE]
                 & (pipe.out_rd == rs) & (rs != '0);

    assign stall   = pipe.in_valid & ((sCnt != '0) | hazLu | hazJr);
    assign inReady = advance & ~flush & ~stall;
    assign accept  = pipe.in_valid & inReady;

    assign pipe.in_ready = inReady;

    assign isJump    = pipe.in_ctrl[CB_JUMP];
    assign isJumpReg = pipe.in_ctrl[CB_JUMPREG];

    // Jumps resolve in ID; reset masks the redirect so fetch never sees a stale one
    assign jump_taken  = rst_n & accept & (isJump | isJumpReg);
    assign jump_target = isJumpReg ? rsData
                                   : {pipe.in_pc4[XLEN-1:28], pipe.in_instr[25:0], 2'b00};

    // ID/EX register and load-use bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.out_valid   <= 1'b0;
            pipe.out_ctrl    <= '0;
            pipe.out_rs_data <= '0;
            pipe.out_rt_data <= '0;
            pipe.out_imm     <= '0;
            pipe.out_rs      <= '0;
            pipe.out_rt      <= '0;
            pipe.out_rd      <= '0;
            sCnt             <= '0;
        end else if (flush) begin
            pipe.out_valid <= 1'b0;
            sCnt           <= '0;
        end else if (!advance) begin
            // EX is back-pressuring: keep the held op and the bubble count unchanged
        end else if (stall) begin
            pipe.out_valid <= 1'b0;
            if (hazLu && (sCnt == '0)) begin
                sCnt <= SCNT_W'(LOAD_LAT - 1);
            end else if (sCnt != '0) begin
                sCnt <= sCnt - 1'b1;
            end
        end else if (accept) begin
            pipe.out_valid   <= 1'b1;
            pipe.out_ctrl    <= pipe.in_ctrl;
            pipe.out_rs_data <= rsData;
            pipe.out_rt_data <= rtData;
            pipe.out_imm     <= XLEN'(imm_ext(pipe.in_instr[15:0], pipe.in_ctrl[CB_ZEROEXT]));
            pipe.out_rs      <= rs;
            pipe.out_rt      <= rt;
            pipe.out_rd      <= pipe.in_rd;
        end else begin
            pipe.out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to hazards while the stage could otherwise move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
        end else if (stall && advance && !flush && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 1'b1;
        end
    end

endmodule
